// File: rtl/demux_pkg.sv
// Shared types and route encodings for the 1-to-2 stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } demux_state_t;

  localparam logic ROUTE_Y0 = 1'b0;
  localparam logic ROUTE_Y1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slice: holds data/last/valid until the downstream accepts.
module demux_out_slot #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              full,
  output logic              done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      // A load wins over a drain in the same cycle, so back-to-back beats keep the slot full.
      full <= 1'b1;
      data <= load_data;
      last <= load_last;
    end else if (full && ready) begin
      full <= 1'b0;
    end
  end

  assign done = full & ready & last;

endmodule

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer: whole packets steered to y0 or y1 by sel on
// the first beat, with per-output packet counters.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              i_ready,
  input  logic              sel,
  output logic [DATA_W-1:0] y0,
  output logic              y0_valid,
  output logic              y0_last,
  input  logic              y0_ready,
  output logic [DATA_W-1:0] y1,
  output logic              y1_valid,
  output logic              y1_last,
  input  logic              y1_ready,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);

  demux_state_t state;
  logic         locked_route;
  logic         eff_route;
  logic         accept;
  logic         load0;
  logic         load1;
  logic         done0;
  logic         done1;

  // The route is taken live from sel only while idle; mid-packet it stays locked.
  assign eff_route = (state == ST_IDLE) ? sel : locked_route;
  assign i_ready   = (eff_route == ROUTE_Y1) ? (~y1_valid | y1_ready) : (~y0_valid | y0_ready);
  assign accept    = i_valid & i_ready;
  assign load0     = accept & (eff_route == ROUTE_Y0);
  assign load1     = accept & (eff_route == ROUTE_Y1);
  assign busy      = (state == ST_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      locked_route <= ROUTE_Y0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!i_last) begin
            state        <= ST_BUSY;
            locked_route <= sel;
          end
        end
        ST_BUSY: begin
          if (i_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  demux_out_slot #(
    .DATA_W(DATA_W)
  ) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load0),
    .load_data(i),
    .load_last(i_last),
    .ready    (y0_ready),
    .data     (y0),
    .last     (y0_last),
    .full     (y0_valid),
    .done     (done0)
  );

  demux_out_slot #(
    .DATA_W(DATA_W)
  ) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load1),
    .load_data(i),
    .load_last(i_last),
    .ready    (y1_ready),
    .data     (y1),
    .last     (y1_last),
    .full     (y1_valid),
    .done     (done1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (done0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (done1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

endmodule
